// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter feeding the WM8978 DAC, framed by the codec LRC,
// with per-word tx_done handshake, sticky short-frame detection and a word counter.
module audio_i2s_tx #(
  parameter int WL      = 16,
  parameter int CH_MODE = 0
) (
  input  logic        aud_bclk,
  input  logic        rst_n,
  input  logic        aud_lrc,
  input  logic [31:0] dac_data,
  input  logic        mute,
  output logic        aud_dacdat,
  output logic        tx_done,
  output logic        sync_err,
  output logic [15:0] word_cnt
);
  localparam int CW = $clog2(WL + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;
  state_t        state_q, state_d;
  logic          lrc_q;
  logic [WL-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dat_q, dat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          right_q, right_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          lrc_edge;
  logic [31:0]   hi_w;
  logic [WL-1:0] sel_w, word_w;
  logic          unused_w;
  assign lrc_edge = aud_lrc ^ lrc_q;
  // zero-extended upper half keeps the left-slice select in range for any WL
  assign hi_w     = {16'b0, dac_data[31:16]};
  assign sel_w    = (CH_MODE != 0 && !aud_lrc) ? hi_w[WL-1:0] : dac_data[WL-1:0];
  assign word_w   = mute ? '0 : sel_w;
  assign unused_w = ^{dac_data, hi_w};
  always_ff @(posedge aud_bclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lrc_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      dat_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      right_q <= 1'b0;
      wcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      lrc_q   <= aud_lrc;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      right_q <= right_d;
      wcnt_q  <= wcnt_d;
    end
  end
  // cnt counts bits already driven; reaching WL means the LSB goes out this edge
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dat_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    right_d = right_q;
    wcnt_d  = wcnt_q;
    if (lrc_edge) begin
      err_d   = err_q | (state_q == SHIFT);
      right_d = aud_lrc;
      dat_d   = word_w[WL-1];
      sh_d    = word_w << 1;
      cnt_d   = CW'(1);
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      dat_d = sh_q[WL-1];
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + CW'(1);
    end
    if (state_d == SHIFT && cnt_d == CW'(WL)) begin
      done_d  = (CH_MODE == 0) || right_d;
      wcnt_d  = wcnt_q + 16'd1;
      state_d = PAD;
    end
  end
  assign aud_dacdat = dat_q;
  assign tx_done    = done_q;
  assign sync_err   = err_q;
  assign word_cnt   = wcnt_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized bench comparing duplicate, packed and WL=1 transmitters
// against a bit-index reference model of the I2S framing rules.
module tb_audio_i2s_tx;
  localparam int WL = 16;
  logic clk = 1'b0, rst_n = 1'b0, aud_lrc = 1'b0, mute = 1'b0;
  logic [31:0] dac_data = 32'h0;
  logic dat0, done0, err0, dat1, done1, err1, dat2, done2, err2;
  logic [15:0] cnt0, cnt1, cnt2;
  int n_chk = 0, n_fail = 0, ph = 0, half = 32;
  always #5 clk = ~clk;
  audio_i2s_tx #(.WL(WL), .CH_MODE(0)) dut0 (.aud_bclk(clk), .rst_n(rst_n), .aud_lrc(aud_lrc),
    .dac_data(dac_data), .mute(mute), .aud_dacdat(dat0), .tx_done(done0), .sync_err(err0), .word_cnt(cnt0));
  audio_i2s_tx #(.WL(WL), .CH_MODE(1)) dut1 (.aud_bclk(clk), .rst_n(rst_n), .aud_lrc(aud_lrc),
    .dac_data(dac_data), .mute(mute), .aud_dacdat(dat1), .tx_done(done1), .sync_err(err1), .word_cnt(cnt1));
  audio_i2s_tx #(.WL(1), .CH_MODE(0)) dut2 (.aud_bclk(clk), .rst_n(rst_n), .aud_lrc(aud_lrc),
    .dac_data(dac_data), .mute(mute), .aud_dacdat(dat2), .tx_done(done2), .sync_err(err2), .word_cnt(cnt2));
  // k = bit index on the wire since the last load edge (-1 = nothing loaded)
  int k = -1;
  logic pl = 1'b0, ch = 1'b0, e_err = 1'b0, e_dat2 = 1'b0, e_done2 = 1'b0;
  logic [15:0] w0 = 16'h0, w1 = 16'h0, e_cnt = 16'h0, e_cnt2 = 16'h0;
  always @(posedge clk) begin
    if (!rst_n) begin
      k = -1; pl = 1'b0; ch = 1'b0; e_err = 1'b0; e_cnt = 16'h0;
      e_dat2 = 1'b0; e_done2 = 1'b0; e_cnt2 = 16'h0;
    end else begin
      if (aud_lrc != pl) begin
        if (k >= 0 && k < WL - 1) e_err = 1'b1;
        k = 0;
        ch = aud_lrc;
        w0 = mute ? 16'h0 : dac_data[15:0];
        w1 = mute ? 16'h0 : (aud_lrc ? dac_data[15:0] : dac_data[31:16]);
        e_dat2 = mute ? 1'b0 : dac_data[0];
        e_done2 = 1'b1;
        e_cnt2 = e_cnt2 + 16'd1;
      end else begin
        if (k >= 0 && k < WL) k = k + 1;
        e_dat2 = 1'b0;
        e_done2 = 1'b0;
      end
      if (k == WL - 1) e_cnt = e_cnt + 16'd1;
      pl = aud_lrc;
    end
  end
  logic bit0, bit1;
  logic [56:0] obs, expv;
  assign bit0 = (k >= 0 && k < WL) ? w0[WL-1-k] : 1'b0;
  assign bit1 = (k >= 0 && k < WL) ? w1[WL-1-k] : 1'b0;
  assign obs  = {dat0, done0, err0, cnt0, dat1, done1, err1, cnt1, dat2, done2, err2, cnt2};
  assign expv = {bit0, k == WL - 1, e_err, e_cnt, bit1, (k == WL - 1) && ch, e_err, e_cnt,
                 e_dat2, e_done2, 1'b0, e_cnt2};

  task automatic tick();
    ph++;
    if (ph >= half) begin ph = 0; aud_lrc = ~aud_lrc; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs !== 57'b0) begin n_fail++; $display("FAIL reset_state obs=%h exp=0", obs); end
    n_chk++;
    if (expv !== 57'b0) begin n_fail++; $display("FAIL reset_model exp=%h", expv); end
    rst_n = 1'b1;
  endtask

  task automatic test_duplicate();
    dac_data = 32'h0000A55A;
    half = 32; ph = 0;
    repeat (256) begin
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL duplicate t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    n_chk++;
    if (err0 !== 1'b0) begin n_fail++; $display("FAIL duplicate_sync_err got=%b exp=0", err0); end
  endtask

  task automatic test_packed();
    dac_data = 32'h80017FFE;
    repeat (256) begin
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL packed t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
  endtask

  task automatic test_mute();
    int g = 0;
    dac_data = 32'h1234C3C3;
    while (!(k == 5 && ch == 1'b0) && g < 200) begin
      tick(); g++;
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL mute_wait t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    n_chk++;
    if (g >= 200) begin n_fail++; $display("FAIL mute_wait_timeout got=%0d limit=200", g); end
    mute = 1'b1;
    repeat (128) begin
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL mute t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    mute = 1'b0;
  endtask

  task automatic test_short_frame();
    dac_data = 32'h5A5A0FF0;
    half = 10; ph = 0;
    repeat (30) begin
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL short t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    half = 32; ph = 0;
    repeat (192) begin
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL short_recover t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    n_chk++;
    if (err0 !== 1'b1 || err1 !== 1'b1) begin n_fail++; $display("FAIL short_sticky got=%b%b exp=11", err0, err1); end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    dac_data = 32'hF00F9669;
    while (k != 7 && g < 200) begin
      tick(); g++;
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL rstmid_wait t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    n_chk++;
    if (g >= 200) begin n_fail++; $display("FAIL rstmid_wait_timeout got=%0d limit=200", g); end
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (obs !== 57'b0) begin n_fail++; $display("FAIL rstmid_zero t=%0t obs=%h exp=0", $time, obs); end
    end
    rst_n = 1'b1;
    repeat (192) begin
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL rstmid_resume t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
  endtask

  task automatic test_random();
    int tbl[8] = '{8, 10, 15, 16, 17, 20, 32, 40};
    repeat (40) begin
      half = tbl[$urandom_range(0, 7)]; ph = 0;
      mute = ($urandom_range(0, 3) == 0);
      repeat (half) begin
        if ($urandom_range(0, 15) == 0) dac_data = $urandom;
        tick();
        n_chk++;
        if (obs !== expv) begin n_fail++; $display("FAIL random t=%0t obs=%h exp=%h", $time, obs, expv); end
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_wrap();
    int g = 0;
    half = 1; ph = 0;
    while (e_cnt2 != 16'hFFFF && g < 70000) begin
      dac_data = $urandom;
      tick(); g++;
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL wrap_run t=%0t obs=%h exp=%h", $time, obs, expv); end
    end
    n_chk++;
    if (cnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got=%h exp=ffff", cnt2); end
    tick();
    n_chk++;
    if (cnt2 !== 16'h0000 || done2 !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got=%h/%b exp=0000/1", cnt2, done2); end
  endtask

  initial begin
    test_reset();
    test_duplicate();
    test_packed();
    test_mute();
    test_short_frame();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
